// File: rtl/ibex_branch_resolve.sv
// ibex_branch_resolve: one-entry branch resolution stage with mispredict flush and saturating event counters
module ibex_branch_resolve (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_valid_i,
  input  logic [6:0]  io_operator_i,
  input  logic        io_comparison_result_i,
  input  logic        io_is_equal_result_i,
  input  logic [31:0] io_pc_i,
  input  logic [31:0] io_imm_i,
  input  logic        io_pred_taken_i,
  input  logic        io_ready_i,
  output logic        io_ready_o,
  output logic        io_valid_o,
  output logic        io_taken_o,
  output logic [31:0] io_target_o,
  output logic [31:0] io_cmp_result_o,
  output logic        io_flush_o,
  output logic [15:0] io_taken_cnt_o,
  output logic [15:0] io_mispred_cnt_o
);
  typedef enum logic [1:0] {IDLE, VALID, FLUSH} state_t;
  state_t state;
  logic mispred_q, flush_cnt, is_br, is_set, taken, in_hs, out_hs, unused_eq;
  assign unused_eq  = io_is_equal_result_i;
  assign is_br      = io_operator_i >= 7'h19 && io_operator_i <= 7'h1E;
  assign is_set     = io_operator_i == 7'h1F || io_operator_i == 7'h20;
  assign taken      = is_br & io_comparison_result_i;
  assign io_valid_o = state == VALID;
  assign out_hs     = io_valid_o & io_ready_i;
  assign io_flush_o = out_hs & mispred_q;
  // a mispredicted entry blocks the pass-through so nothing enters alongside the flush
  assign io_ready_o = state == IDLE || (out_hs && !mispred_q);
  assign in_hs      = io_valid_i & io_ready_o;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state            <= IDLE;
      flush_cnt        <= 1'b0;
      mispred_q        <= 1'b0;
      io_taken_o       <= 1'b0;
      io_target_o      <= 32'h0;
      io_cmp_result_o  <= 32'h0;
      io_taken_cnt_o   <= 16'h0;
      io_mispred_cnt_o <= 16'h0;
    end else begin
      if (in_hs) begin
        io_taken_o      <= taken;
        io_target_o     <= io_pc_i + (taken ? io_imm_i : 32'h4);
        io_cmp_result_o <= is_set ? {31'b0, io_comparison_result_i} : 32'h0;
        mispred_q       <= is_br && taken != io_pred_taken_i;
      end
      if (out_hs && io_taken_o && io_taken_cnt_o != 16'hFFFF)
        io_taken_cnt_o <= io_taken_cnt_o + 16'd1;
      if (io_flush_o && io_mispred_cnt_o != 16'hFFFF)
        io_mispred_cnt_o <= io_mispred_cnt_o + 16'd1;
      flush_cnt <= state == FLUSH && !flush_cnt;
      state <= state == IDLE  ? (in_hs ? VALID : IDLE) :
               state == VALID ? (io_flush_o ? FLUSH : (out_hs && !in_hs) ? IDLE : VALID) :
               (flush_cnt ? IDLE : FLUSH);
    end
endmodule

// File: tb/tb_ibex_branch_resolve.sv
// tb_ibex_branch_resolve: randomized scoreboard bench for ibex_branch_resolve
module tb_ibex_branch_resolve;
  logic        clock = 0, reset_n = 0, io_valid_i = 0, io_comparison_result_i = 0;
  logic        io_is_equal_result_i = 0, io_pred_taken_i = 0, io_ready_i = 0;
  logic [6:0]  io_operator_i = 0;
  logic [31:0] io_pc_i = 0, io_imm_i = 0;
  logic        io_ready_o, io_valid_o, io_taken_o, io_flush_o;
  logic [31:0] io_target_o, io_cmp_result_o;
  logic [15:0] io_taken_cnt_o, io_mispred_cnt_o;

  ibex_branch_resolve dut (
    .clock(clock), .reset_n(reset_n), .io_valid_i(io_valid_i), .io_operator_i(io_operator_i),
    .io_comparison_result_i(io_comparison_result_i), .io_is_equal_result_i(io_is_equal_result_i),
    .io_pc_i(io_pc_i), .io_imm_i(io_imm_i), .io_pred_taken_i(io_pred_taken_i),
    .io_ready_i(io_ready_i), .io_ready_o(io_ready_o), .io_valid_o(io_valid_o),
    .io_taken_o(io_taken_o), .io_target_o(io_target_o), .io_cmp_result_o(io_cmp_result_o),
    .io_flush_o(io_flush_o), .io_taken_cnt_o(io_taken_cnt_o), .io_mispred_cnt_o(io_mispred_cnt_o));

  always #5 clock = ~clock;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] cmp;
    logic        misp;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, hold = 0;
  int m_tc = 0, m_mc = 0;
  bit has, ohs, fl;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, x, $time);
    end
  endtask

  function automatic exp_t model(input logic [6:0] op, input logic c, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic p);
    exp_t r;
    bit br = op inside {7'h19, 7'h1A, 7'h1B, 7'h1C, 7'h1D, 7'h1E};
    bit st = op inside {7'h1F, 7'h20};
    r.taken  = br && c;
    r.target = r.taken ? pc + imm : pc + 32'd4;
    r.cmp    = (st && c) ? 32'd1 : 32'd0;
    r.misp   = br && (r.taken != p);
    return r;
  endfunction

  // Monitor: compares the presented entry with the oldest expected one and tracks flush/counter effects
  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      chk("rst_valid", io_valid_o, 0);
      chk("rst_taken", io_taken_o, 0);
      chk("rst_target", io_target_o, 0);
      chk("rst_cmp", io_cmp_result_o, 0);
      chk("rst_flush", io_flush_o, 0);
      chk("rst_taken_cnt", io_taken_cnt_o, 0);
      chk("rst_mispred_cnt", io_mispred_cnt_o, 0);
      q.delete();
      m_tc = 0; m_mc = 0; hold = 0;
    end else begin
      has = q.size() != 0;
      ohs = has && io_ready_i;
      fl  = ohs && q[0].misp;
      chk("valid_o", io_valid_o, has);
      chk("ready_o", io_ready_o, hold == 0 && (!has || (io_ready_i && !q[0].misp)));
      if (has) begin
        chk("taken_o", io_taken_o, q[0].taken);
        chk("target_o", io_target_o, q[0].target);
        chk("cmp_result_o", io_cmp_result_o, q[0].cmp);
      end
      chk("flush_o", io_flush_o, fl);
      chk("taken_cnt", io_taken_cnt_o, m_tc);
      chk("mispred_cnt", io_mispred_cnt_o, m_mc);
      if (ohs) begin
        e = q.pop_front();
        if (e.taken && m_tc != 16'hFFFF) m_tc++;
        if (e.misp) begin
          if (m_mc != 16'hFFFF) m_mc++;
          hold = 2;
        end
      end else if (hold > 0) hold--;
      if (io_valid_i && io_ready_o)
        q.push_back(model(io_operator_i, io_comparison_result_i, io_pc_i, io_imm_i, io_pred_taken_i));
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input logic [6:0] op, input logic c, input logic eq, input logic [31:0] pc,
                      input logic [31:0] imm, input logic p, input bit rnd);
    bit ok = 0;
    io_valid_i = 1; io_operator_i = op; io_comparison_result_i = c; io_is_equal_result_i = eq;
    io_pc_i = pc; io_imm_i = imm; io_pred_taken_i = p;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clock);
      ok = io_ready_o;
      @(posedge clock); #1;
      if (!ok && rnd) io_ready_i = 1'($urandom_range(0, 1));
    end
    io_valid_i = 0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=no_accept expected=accept op=%h", op);
    end
  endtask

  initial begin
    step(3);
    reset_n = 1;
    io_ready_i = 1;
    step(1);
    send(7'h1D, 1, 1, 32'h100, 32'h20, 1, 0);
    step(2);
    send(7'h1E, 0, 1, 32'hFFFFFFFC, 32'h40, 1, 0);
    step(5);
    send(7'h20, 1, 0, 32'h40, 32'h8, 1, 0);
    step(2);
    io_ready_i = 0;
    send(7'h1C, 1, 0, 32'h200, 32'hFFFFFFF8, 1, 0);
    step(3);
    io_ready_i = 1;
    for (int i = 0; i < 5; i++) send(7'h1D, 1, 1, 32'h1000 + 32'(i * 4), 32'h10, 1, 0);
    step(2);
    for (int i = 0; i < 400; i++) begin
      io_ready_i = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 4) == 0) step(1);
      else send($urandom_range(0, 7) == 0 ? 7'($urandom) : 7'($urandom_range(7'h17, 7'h22)),
                1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), 1);
    end
    io_ready_i = 1;
    step(4);
    send(7'h1A, 0, 0, 32'h300, 32'h30, 1, 0);
    @(posedge clock); #1;
    reset_n = 0;
    #1;
    chk("async_rst_valid", io_valid_o, 0);
    chk("async_rst_flush", io_flush_o, 0);
    chk("async_rst_target", io_target_o, 0);
    chk("async_rst_mispred_cnt", io_mispred_cnt_o, 0);
    step(2);
    reset_n = 1;
    step(1);
    for (int i = 0; i < 65540; i++) send(7'h19, 1, 0, 32'h4000, 32'h100, 1, 0);
    step(3);
    chk("taken_cnt_sat", io_taken_cnt_o, 32'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
